// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last cycle of each CLKS_PER_BIT-cycle bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // restart holds the counter at zero so the first bit after it is full length
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       Ready_Byte,
    output logic       Tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Ready_Byte) begin
                    shift_d    = din;
                    par_d      = (^din) ^ (PARITY_ODD != 0);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx is registered yet aligned with it
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign Tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Three transmitter configurations driven by directed then random strobes; per-cycle line model plus frame scoreboard.
module tb_uart_tx_serializer;

    localparam int NC = 3;

    typedef struct {
        logic [7:0] b;
        int         e;
    } exp_t;

    function automatic int f_cpb(input int c);   return (c == 2) ? 3 : 10; endfunction
    function automatic int f_pen(input int c);   return (c != 0) ? 1 : 0;  endfunction
    function automatic int f_odd(input int c);   return (c == 2) ? 1 : 0;  endfunction
    function automatic int f_sb(input int c);    return (c == 1) ? 2 : 1;  endfunction
    function automatic int f_nbits(input int c); return 9 + f_pen(c) + f_sb(c); endfunction
    function automatic int f_frame(input int c); return f_cpb(c) * f_nbits(c); endfunction

    function automatic logic f_par(input int c, input logic [7:0] b);
        return ((($countones(b) + f_odd(c)) % 2) == 1);
    endfunction

    // Line level during bit k of a frame carrying byte b
    function automatic logic f_line(input int c, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (f_pen(c) == 1 && k == 9) return f_par(c, b);
        return 1'b1;
    endfunction

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   rdy;
    logic [7:0]      din [NC];
    logic [NC-1:0]   busy, done, txl;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .din(din[0]), .Ready_Byte(rdy[0]),
        .Tx_busy(busy[0]), .tx_done(done[0]), .tx(txl[0])
    );

    uart_tx_serializer #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din[1]), .Ready_Byte(rdy[1]),
        .Tx_busy(busy[1]), .tx_done(done[1]), .tx(txl[1])
    );

    uart_tx_serializer #(
        .CLK_FREQ(300_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
    ) dut2 (
        .clk(clk), .rst(rst), .din(din[2]), .Ready_Byte(rdy[2]),
        .Tx_busy(busy[2]), .tx_done(done[2]), .tx(txl[2])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp, input int cy);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d cycle %0d: got %0h expected %0h", name, c, cy, act, exp);
        end
    endtask

    // Reference model state, updated once per rising edge
    int         cyc = 0;
    int         last_rst = -1;
    bit         chk_en = 1'b0;
    bit         acc_v   [NC];
    int         acc_edge[NC];
    int         next_ok [NC];
    logic [7:0] acc_byte[NC];
    logic       e_tx[NC], e_busy[NC], e_done[NC];
    exp_t       sbq[NC][$];

    initial begin
        for (int c = 0; c < NC; c++) begin
            acc_v[c] = 1'b0; next_ok[c] = 0; acc_edge[c] = 0; acc_byte[c] = '0;
            e_tx[c] = 1'b1; e_busy[c] = 1'b0; e_done[c] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                chk_en   = 1'b1;
                last_rst = cyc;
            end
            for (int c = 0; c < NC; c++) begin
                int d;
                if (rst) begin
                    acc_v[c]   = 1'b0;
                    next_ok[c] = cyc + 1;
                    sbq[c].delete();
                end else if (rdy[c] && cyc >= next_ok[c]) begin
                    acc_v[c]    = 1'b1;
                    acc_edge[c] = cyc;
                    acc_byte[c] = din[c];
                    next_ok[c]  = cyc + f_frame(c) + 1;
                    sbq[c].push_back('{din[c], cyc});
                end
                d = cyc - acc_edge[c];
                if (acc_v[c] && d < f_frame(c)) begin
                    e_busy[c] = 1'b1;
                    e_tx[c]   = f_line(c, acc_byte[c], d / f_cpb(c));
                end else begin
                    e_busy[c] = 1'b0;
                    e_tx[c]   = 1'b1;
                end
                e_done[c] = acc_v[c] && (d == f_frame(c));
            end
        end
    end

    // Monitor: per-cycle line check, mid-bit receiver, scoreboard pop on tx_done
    bit         rx_act [NC];
    int         rx_t   [NC];
    int         rx_start[NC];
    logic [11:0] rx_bits[NC];
    logic       rx_prev[NC];

    initial begin
        for (int c = 0; c < NC; c++) begin
            rx_act[c] = 1'b0; rx_t[c] = 0; rx_start[c] = 0; rx_bits[c] = '0; rx_prev[c] = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int c = 0; c < NC; c++) begin
                    check("tx", c, 32'(txl[c]), 32'(e_tx[c]), cyc);
                    check("Tx_busy", c, 32'(busy[c]), 32'(e_busy[c]), cyc);
                    check("tx_done", c, 32'(done[c]), 32'(e_done[c]), cyc);

                    if (last_rst == cyc) begin
                        rx_act[c] = 1'b0;
                    end else if (!rx_act[c]) begin
                        if (txl[c] === 1'b0 && rx_prev[c] === 1'b1) begin
                            rx_act[c] = 1'b1; rx_t[c] = 0; rx_start[c] = cyc; rx_bits[c] = '0;
                        end
                    end else begin
                        rx_t[c]++;
                    end
                    if (rx_act[c] && (rx_t[c] % f_cpb(c)) == (f_cpb(c) / 2)) begin
                        int k;
                        k = rx_t[c] / f_cpb(c);
                        rx_bits[c][k] = txl[c];
                        if (k == f_nbits(c) - 1) rx_act[c] = 1'b0;
                    end
                    rx_prev[c] = txl[c];

                    if (done[c] === 1'b1) begin
                        if (sbq[c].size() == 0) begin
                            check("unexpected_done", c, 32'(1), 32'(0), cyc);
                        end else begin
                            exp_t ex;
                            logic [3:0] stops;
                            ex = sbq[c].pop_front();
                            check("rx_start_bit", c, 32'(rx_bits[c][0]), 32'(0), cyc);
                            check("rx_byte", c, 32'(rx_bits[c][8:1]), 32'(ex.b), cyc);
                            if (f_pen(c) == 1)
                                check("rx_parity", c, 32'(rx_bits[c][9]), 32'(f_par(c, ex.b)), cyc);
                            stops = '0;
                            for (int s = 0; s < f_sb(c); s++)
                                stops[s] = rx_bits[c][9 + f_pen(c) + s];
                            check("rx_stop", c, 32'(stops), 32'((1 << f_sb(c)) - 1), cyc);
                            check("frame_start", c, 32'(rx_start[c]), 32'(ex.e), cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        for (int c = 0; c < NC; c++) din[c] = b;
        rdy = '1;
        tick(1);
        rdy = '0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = '1;
        for (int c = 0; c < NC; c++) din[c] = 8'hFF;
        tick(3);
        rst = 1'b0;
        rdy = '0;
        tick(2);

        strobe(8'hA5);
        tick(130);

        // Second strobe lands while the first frame is in flight
        strobe(8'h3C);
        tick(39);
        strobe(8'hFF);
        tick(130);

        // Strobe held high across frame boundaries
        for (int c = 0; c < NC; c++) din[c] = 8'h55;
        rdy = '1;
        tick(1);
        for (int c = 0; c < NC; c++) din[c] = 8'h01;
        tick(130);
        rdy = '0;
        tick(250);

        strobe(8'h07);
        tick(130);

        strobe(8'hF0);
        tick(44);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        strobe(8'h0F);
        tick(130);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                rdy[c] = ($urandom_range(0, 7) == 0);
                din[c] = 8'($urandom);
            end
            rst = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        rst = 1'b0;
        rdy = '0;

        for (int i = 0; i < 300; i++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
            tick(1);
        end
        tick(2);
        for (int c = 0; c < NC; c++)
            check("drain", c, 32'(sbq[c].size()), 32'(0), cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
